// File: rtl/fetch_queue_ctrl_if.sv
// Fetch/decode-side signal bundle for fetch_queue_ctrl.
// master = the controller, slave = the fetch memory plus decode environment.
interface fetch_queue_ctrl_if #(
  parameter int DEPTH = 4
);
  logic [31:0]            fetch_pc;
  logic [31:0]            fetch_inst;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   halt;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic [$clog2(DEPTH):0] count;
  logic                   fault;

  modport master (
    output fetch_pc,
    input  fetch_inst,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output count,
    output fault
  );

  modport slave (
    input  fetch_pc,
    output fetch_inst,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  count,
    input  fault
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// PC sequencer plus {pc, inst} queue between the fetch stage and decode.
// Handles decode back-pressure, redirect flushes, halt and misaligned-target faults.
module fetch_queue_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          fault_reg;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic redirect;
  logic misaligned;
  logic do_push;
  logic do_pop;

  // FAULT is terminal: redirects are ignored there until reset.
  always_comb begin
    redirect   = bus.redirect_valid && (state_reg != ST_FAULT);
    misaligned = (bus.redirect_pc[1:0] != 2'b00);
    do_push    = (state_reg == ST_RUN) && !bus.redirect_valid && !bus.halt &&
                 (count_reg != FULL_COUNT);
    do_pop     = (count_reg != '0) && bus.out_ready && !redirect;
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect) begin
      if (misaligned) begin
        state_next = ST_FAULT;
        pc_next    = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        state_next = bus.halt ? ST_HALT : ST_RUN;
        pc_next    = bus.redirect_pc;
      end
    end else begin
      case (state_reg)
        ST_RUN:  if (bus.halt)  state_next = ST_HALT;
        ST_HALT: if (!bus.halt) state_next = ST_RUN;
        default: state_next = state_reg;
      endcase
      if (do_push) pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        if (misaligned) fault_reg <= 1'b1;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      inst_mem[wr_ptr_reg] <= bus.fetch_inst;
    end
  end

  assign bus.fetch_pc  = pc_reg;
  assign bus.out_valid = (count_reg != '0);
  assign bus.out_pc    = pc_mem[rd_ptr_reg];
  assign bus.out_inst  = inst_mem[rd_ptr_reg];
  assign bus.count     = count_reg;
  assign bus.fault     = fault_reg;
endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
- PC sequencer plus instruction queue sitting directly upstream/around the fetch stage.
- Drives the fetch PC into the fetch stage, which returns the instruction word combinationally in the same cycle.
- Captures {pc, inst} pairs into a FIFO and presents them to decode over a valid/ready handshake.
- Absorbs decode back-pressure, branch/jump redirects (queue flush), halt requests and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_pc  out  32  address driven to the fetch stage; equals the internal PC register.
- fetch_inst  in  32  instruction at fetch_pc, valid in the same cycle (combinational memory read).
- redirect_valid  in  1  one-cycle pulse: taken branch, jump or trap.
- redirect_pc  in  32  redirect target; sampled when redirect_valid=1.
- halt  in  1  level; while 1, no new fetches are enqueued.
- out_valid  out  1  queue head valid (count != 0).
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  instruction of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- fault  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async, rst=1): state=RUN; PC=RESET_PC; count=0 and rd/wr pointers=0; fault=0; out_valid=0. out_pc/out_inst are don't-care while out_valid=0.
- States:
  - RUN: normal fetching.
  - HALT: halt=1.
  - FAULT: misaligned redirect seen; terminal until reset.
- State transitions, priority in this order:
  - rst.
  - redirect_valid with redirect_pc[1:0] != 0 → FAULT.
  - redirect_valid with aligned target → RUN if halt=0, else HALT.
  - RUN with halt=1 → HALT.
  - HALT with halt=0 → RUN.
- Push, RUN only:
  - Condition: redirect_valid=0, halt=0 and count < DEPTH, evaluated on the current-cycle count.
  - A full queue never pushes, even if a pop occurs the same cycle.
  - Action: write {fetch_pc, fetch_inst} at wr_ptr; PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
  - If the push condition fails, PC holds.
- Pop: occurs when out_valid && out_ready; rd_ptr advances.
  - Simultaneous push and pop → count unchanged.
- Output timing: out_pc/out_inst read from the head of registered storage. An instruction fetched in cycle N is presented at the earliest in cycle N+1; there is no combinational path from fetch_inst to out_*.
- Redirect (aligned), highest priority after reset:
  - Queue flushed: count=0 and pointers reset to 0. Any same-cycle pop is discarded; no push.
  - PC <= redirect_pc.
  - out_valid=0 in the following cycle; the first post-redirect entry appears in the cycle after that.
- Redirect (misaligned):
  - Queue flushed; PC <= {redirect_pc[31:2], 2'b00}; fault <= 1.
  - State FAULT: no pushes until reset; out_valid stays 0.
- HALT: the queue still drains to decode; PC frozen. Redirects are still honoured while halted.
- Flush is not re-triggered by out_ready; back-pressure never drops or duplicates entries.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.

Test Plan:
- Reset release with RESET_PC=0, out_ready=1, memory word i = 32'h1000_0000+i → out_pc sequence 0,4,8,… one per cycle from the cycle after release; out_inst matches; count stays 1.
- out_ready=0 for 10 cycles → count reaches 4 by cycle 4, fetch_pc frozen at 32'h10. Then out_ready=1 → entries drain in order 0,4,8,C followed by 10.
- Full queue with redirect_valid=1, redirect_pc=32'h200 and out_ready=1 in the same cycle → next cycle count=0 and out_valid=0, fetch_pc=32'h200; following cycle out_pc=32'h200.
- halt=1 for 5 cycles with 3 entries queued and out_ready=1 → 3 entries drain, then out_valid=0 and fetch_pc constant. halt=0 → fetching resumes at the held PC.
- redirect_pc=32'h0000_0106 → fault=1 sticky, out_valid=0 forever, fetch_pc=32'h104. rst pulse mid-run → fault=0, fetch_pc=RESET_PC, count=0 immediately (asynchronous).
- redirect_pc=32'hFFFF_FFF8, memory modelled at wrapped addresses → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
